// File: rtl/fmc_adc_thres_trig.sv
// Per-channel threshold trigger detector: hysteresis arming, slope polarity, delayed one-cycle pulse.
// Optional build macro FMC_ADC_TRIG_GLITCH_FILTER_EN: arming and firing need two consecutive valid samples.

module fmc_adc_thres_trig #(
    parameter int g_NB_CHAN    = 4,
    parameter int g_DATA_WIDTH = 16,
    parameter int g_DLY_WIDTH  = 32
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [g_NB_CHAN*g_DATA_WIDTH-1:0] data_i,
    input  logic                              data_valid_i,
    input  logic [g_NB_CHAN*g_DATA_WIDTH-1:0] thres_val_i,
    input  logic [g_NB_CHAN*g_DATA_WIDTH-1:0] thres_hyst_i,
    input  logic [g_NB_CHAN-1:0]              pol_i,
    input  logic [g_NB_CHAN-1:0]              en_i,
    input  logic [g_NB_CHAN*g_DLY_WIDTH-1:0]  dly_i,
    output logic [g_NB_CHAN-1:0]              trig_o,
    output logic                              trig_any_o
);

    localparam int NC  = g_NB_CHAN;
    localparam int DW  = g_DATA_WIDTH;
    localparam int DLW = g_DLY_WIDTH;
    // One guard bit beyond the sign so a full-scale hysteresis cannot wrap before saturation.
    localparam int LW  = g_DATA_WIDTH + 2;

    localparam logic [DLW-1:0] CNT_ZERO = {DLW{1'b0}};
    localparam logic [DLW-1:0] CNT_ONE  = {{(DLW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_DELAY    = 2'd2
    } state_t;

    function automatic logic [DW-1:0] sat_limit(input logic signed [LW-1:0] v);
        logic signed [LW-1:0] max_v;
        logic signed [LW-1:0] min_v;
        max_v = {3'b000, {(DW-1){1'b1}}};
        min_v = {3'b111, {(DW-1){1'b0}}};
        if (v > max_v) begin
            sat_limit = max_v[DW-1:0];
        end else if (v < min_v) begin
            sat_limit = min_v[DW-1:0];
        end else begin
            sat_limit = v[DW-1:0];
        end
    endfunction

    logic [NC-1:0] arm_raw_s;
    logic [NC-1:0] fire_raw_s;

    for (genvar g = 0; g < NC; g++) begin : g_cmp
        logic signed [DW-1:0] smp_s;
        logic signed [DW-1:0] thr_s;
        logic signed [DW-1:0] lo_s;
        logic signed [DW-1:0] hi_s;
        logic [DW-1:0]        hyst_s;
        logic signed [LW-1:0] thr_ext_s;
        logic signed [LW-1:0] hyst_ext_s;

        assign smp_s      = data_i[g*DW +: DW];
        assign thr_s      = thres_val_i[g*DW +: DW];
        assign hyst_s     = thres_hyst_i[g*DW +: DW];
        assign thr_ext_s  = {{2{thr_s[DW-1]}}, thr_s};
        assign hyst_ext_s = {2'b00, hyst_s};
        assign lo_s       = sat_limit(thr_ext_s - hyst_ext_s);
        assign hi_s       = sat_limit(thr_ext_s + hyst_ext_s);

        assign arm_raw_s[g]  = pol_i[g] ? (smp_s > hi_s)   : (smp_s < lo_s);
        assign fire_raw_s[g] = pol_i[g] ? (smp_s <= thr_s) : (smp_s >= thr_s);
    end

    logic          valid_d;
    logic          valid_q;
    logic [NC-1:0] arm_d;
    logic [NC-1:0] arm_q;
    logic [NC-1:0] fire_d;
    logic [NC-1:0] fire_q;

`ifdef FMC_ADC_TRIG_GLITCH_FILTER_EN
    logic [NC-1:0] prev_arm_d;
    logic [NC-1:0] prev_arm_q;
    logic [NC-1:0] prev_fire_d;
    logic [NC-1:0] prev_fire_q;

    // Qualify conditions with the previous valid sample; history only advances on valid samples.
    always_comb begin
        valid_d     = data_valid_i;
        arm_d       = {NC{1'b0}};
        fire_d      = {NC{1'b0}};
        prev_arm_d  = prev_arm_q;
        prev_fire_d = prev_fire_q;
        if (data_valid_i) begin
            arm_d       = arm_raw_s & prev_arm_q;
            fire_d      = fire_raw_s & prev_fire_q;
            prev_arm_d  = arm_raw_s;
            prev_fire_d = fire_raw_s;
        end else begin
            arm_d  = {NC{1'b0}};
            fire_d = {NC{1'b0}};
        end
    end

    // Glitch-filter history registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_arm_q  <= {NC{1'b0}};
            prev_fire_q <= {NC{1'b0}};
        end else begin
            prev_arm_q  <= prev_arm_d;
            prev_fire_q <= prev_fire_d;
        end
    end
`else
    // Single-sample arming and firing.
    always_comb begin
        valid_d = data_valid_i;
        arm_d   = arm_raw_s;
        fire_d  = fire_raw_s;
    end
`endif

    // Compare stage register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            arm_q   <= {NC{1'b0}};
            fire_q  <= {NC{1'b0}};
        end else begin
            valid_q <= valid_d;
            arm_q   <= arm_d;
            fire_q  <= fire_d;
        end
    end

    state_t         state_d [NC];
    state_t         state_q [NC];
    logic [DLW-1:0] cnt_d   [NC];
    logic [DLW-1:0] cnt_q   [NC];
    logic [NC-1:0]  trig_d;
    logic [NC-1:0]  trig_q;
    logic           trig_any_d;
    logic           trig_any_q;

    // Per-channel trigger FSM; only valid samples advance it, enable low cancels everything.
    always_comb begin
        trig_d = {NC{1'b0}};
        for (int c = 0; c < NC; c++) begin
            state_d[c] = state_q[c];
            cnt_d[c]   = cnt_q[c];
            if (!en_i[c]) begin
                state_d[c] = ST_DISARMED;
                cnt_d[c]   = CNT_ZERO;
            end else if (valid_q) begin
                case (state_q[c])
                    ST_DISARMED: begin
                        if (arm_q[c]) begin
                            state_d[c] = ST_ARMED;
                        end else begin
                            state_d[c] = ST_DISARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (!fire_q[c]) begin
                            state_d[c] = ST_ARMED;
                        end else if (dly_i[c*DLW +: DLW] == CNT_ZERO) begin
                            trig_d[c]  = 1'b1;
                            state_d[c] = ST_DISARMED;
                        end else begin
                            cnt_d[c]   = dly_i[c*DLW +: DLW];
                            state_d[c] = ST_DELAY;
                        end
                    end
                    ST_DELAY: begin
                        if (cnt_q[c] <= CNT_ONE) begin
                            trig_d[c]  = 1'b1;
                            cnt_d[c]   = CNT_ZERO;
                            state_d[c] = ST_DISARMED;
                        end else begin
                            cnt_d[c] = cnt_q[c] - CNT_ONE;
                        end
                    end
                    default: begin
                        state_d[c] = ST_DISARMED;
                        cnt_d[c]   = CNT_ZERO;
                    end
                endcase
            end else begin
                state_d[c] = state_q[c];
            end
        end
        trig_any_d = |trig_d;
    end

    // FSM and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NC; c++) begin
                state_q[c] <= ST_DISARMED;
                cnt_q[c]   <= CNT_ZERO;
            end
            trig_q     <= {NC{1'b0}};
            trig_any_q <= 1'b0;
        end else begin
            for (int c = 0; c < NC; c++) begin
                state_q[c] <= state_d[c];
                cnt_q[c]   <= cnt_d[c];
            end
            trig_q     <= trig_d;
            trig_any_q <= trig_any_d;
        end
    end

    assign trig_o     = trig_q;
    assign trig_any_o = trig_any_q;

endmodule
